control_secuencia_eval: RTL and testbench
=========================================

Name: control_secuencia_eval

Overview:
- Top-level sequencer for the constant/function/accumulator evaluation datapath.
- Accepts one input sample at a time from the acquisition side and latches it for the datapath.
- Fires the evaluator's start flag and waits for its done flag, with a timeout.
- Captures the result, presents it with a one-cycle valid strobe, and keeps sticky error flags plus a saturating overrun counter.

Parameters:
- DW, 16, width of sample and result words
- TIMEOUT, 16, maximum cycles in WAIT before aborting (≥2)
- CW, 8, width of overrun counter and processed-sample counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- muestra_valid  in  1  one-cycle strobe: new sample on muestra_in
- muestra_in  in  DW  input sample
- eval_listo  in  1  evaluator done flag (level, stays high until next start)
- resultado_in  in  DW  evaluator accumulator output
- clear_err  in  1  clears timeout_err and overrun (not counters)
- dato_out  out  DW  latched sample driven to the datapath
- start_eval  out  1  evaluator start/restart flag (Bandera)
- resultado_out  out  DW  captured result
- resultado_valid  out  1  one-cycle strobe, resultado_out updated this cycle
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky, evaluator missed TIMEOUT
- overrun  out  1  sticky, sample dropped while busy
- cnt_overrun  out  CW  saturating count of dropped samples
- cnt_muestras  out  CW  wrapping count of successful captures

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, all outputs 0, including dato_out, resultado_out and counters.
- States: IDLE, LOAD, START, WAIT, CAPTURE. Registered state, with a separate combinational next-state block.
- IDLE:
  - busy=0, start_eval=0.
  - On muestra_valid: dato_out<=muestra_in, go to LOAD.
- LOAD: 1 cycle, lets the datapath settle on dato_out. Go to START.
- START:
  - start_eval=1 for exactly this one cycle.
  - WAIT timer cleared to 0. Go to WAIT.
- WAIT:
  - start_eval=0, timer increments every cycle.
  - eval_listo is ignored on the first WAIT cycle (timer==0), which blanks a stale done from the previous run.
  - From timer≥1: if eval_listo=1, go to CAPTURE.
  - If timer==TIMEOUT-1 and eval_listo=0: set timeout_err, go to IDLE, no result strobe, cnt_muestras unchanged.
  - If eval_listo and the timeout condition coincide, done wins and the block goes to CAPTURE.
- CAPTURE:
  - resultado_out<=resultado_in; resultado_valid=1 for this cycle only.
  - cnt_muestras+1, wrapping at 2^CW. Go to IDLE.
- Latency: muestra_valid at cycle 0 gives LOAD at c1, start_eval at c2, WAIT from c3. With eval_listo high at c4, resultado_valid is at c5. Minimum sample-to-result latency is 5 cycles.
- Overrun:
  - muestra_valid in any state other than IDLE, CAPTURE included, drops the sample and leaves dato_out unchanged.
  - It also sets overrun and increments cnt_overrun, which saturates at 2^CW-1.
- clear_err and a new error in the same cycle: the set wins and the flag stays 1.
- muestra_valid in the IDLE cycle immediately after CAPTURE or a timeout is accepted normally.
- rst_n low mid-operation, in any state: the next edge forces the reset values. start_eval drops and any in-flight result is discarded.
- Counters and timer are unsigned. The timer width is ceil(log2(TIMEOUT))+1 so the compare never wraps.

Test Plan:
- Reset, then muestra_in=16'h1234 strobed at c0, eval_listo rises at c4 with resultado_in=16'hBEEF -> dato_out=1234 from c1, start_eval high only at c2, resultado_valid only at c5, resultado_out=BEEF, cnt_muestras=1, busy low at c6.
- Start with eval_listo held high from a prior run (stale); it falls at c4 and rises again at c9 -> the first WAIT cycle ignores it and the block stays in WAIT. Capture occurs at c10 with no early strobe.
- eval_listo never rises, TIMEOUT=16 -> timeout_err=1 at the edge leaving WAIT 16 cycles after entry, busy=0 on the next cycle, no resultado_valid, cnt_muestras unchanged. A new sample is then accepted normally.
- muestra_valid pulses at c1, c3 and c5 during an active run -> 3 drops, cnt_overrun=3, overrun=1, dato_out keeps the original sample. With CW=8 and 300 drops, cnt_overrun=255.
- clear_err asserted together with an overrun strobe -> overrun stays 1. clear_err alone on a later cycle -> overrun=0, timeout_err=0, counters unchanged.
- rst_n=0 during WAIT with eval_listo rising in the same cycle -> no resultado_valid. All outputs are 0 at the next edge, and the state is IDLE after rst_n returns high.

Source files
------------

// File: rtl/control_secuencia_eval.sv
// Sequencer for the constant/function/accumulator evaluator: latches a sample, pulses start,
// waits for done (with timeout), captures the result and tracks dropped samples.
module control_secuencia_eval #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          muestra_valid,
    input  logic [DW-1:0] muestra_in,
    input  logic          eval_listo,
    input  logic [DW-1:0] resultado_in,
    input  logic          clear_err,
    output logic [DW-1:0] dato_out,
    output logic          start_eval,
    output logic [DW-1:0] resultado_out,
    output logic          resultado_valid,
    output logic          busy,
    output logic          timeout_err,
    output logic          overrun,
    output logic [CW-1:0] cnt_overrun,
    output logic [CW-1:0] cnt_muestras
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        CAPTURE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic          listo_ok;
    logic          timer_end;
    logic          drop;

    // The first WAIT cycle ignores eval_listo so a done level left over from the previous run is blanked.
    assign listo_ok  = (timer != '0) && eval_listo;
    assign timer_end = (timer == TW'(TIMEOUT - 1));
    assign drop      = muestra_valid && (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (muestra_valid) state_next = LOAD;
            LOAD:    state_next = START;
            START:   state_next = WAIT;
            WAIT: begin
                if (listo_ok)       state_next = CAPTURE;
                else if (timer_end) state_next = IDLE;
            end
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            timer           <= '0;
            dato_out        <= '0;
            start_eval      <= 1'b0;
            resultado_out   <= '0;
            resultado_valid <= 1'b0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
            overrun         <= 1'b0;
            cnt_overrun     <= '0;
            cnt_muestras    <= '0;
        end else begin
            state           <= state_next;
            busy            <= (state_next != IDLE);
            start_eval      <= (state_next == START);
            resultado_valid <= (state_next == CAPTURE);

            if (state == IDLE && muestra_valid)
                dato_out <= muestra_in;

            if (state == START)
                timer <= '0;
            else if (state == WAIT)
                timer <= timer + 1'b1;

            if (state == WAIT && state_next == CAPTURE) begin
                resultado_out <= resultado_in;
                cnt_muestras  <= cnt_muestras + 1'b1;
            end

            // A new error in the same cycle as clear_err keeps the flag set.
            if (state == WAIT && state_next == IDLE)
                timeout_err <= 1'b1;
            else if (clear_err)
                timeout_err <= 1'b0;

            if (drop) begin
                overrun <= 1'b1;
                if (cnt_overrun != '1)
                    cnt_overrun <= cnt_overrun + 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_control_secuencia_eval.sv
// Directed self-checking bench for control_secuencia_eval (DW=16, TIMEOUT=16, CW=8).
module tb_control_secuencia_eval;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        muestra_valid;
    logic [15:0] muestra_in;
    logic        eval_listo;
    logic [15:0] resultado_in;
    logic        clear_err;
    logic [15:0] dato_out;
    logic        start_eval;
    logic [15:0] resultado_out;
    logic        resultado_valid;
    logic        busy;
    logic        timeout_err;
    logic        overrun;
    logic [7:0]  cnt_overrun;
    logic [7:0]  cnt_muestras;

    int compared   = 0;
    int mismatched = 0;

    control_secuencia_eval #(.DW(16), .TIMEOUT(16), .CW(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .muestra_valid   (muestra_valid),
        .muestra_in      (muestra_in),
        .eval_listo      (eval_listo),
        .resultado_in    (resultado_in),
        .clear_err       (clear_err),
        .dato_out        (dato_out),
        .start_eval      (start_eval),
        .resultado_out   (resultado_out),
        .resultado_valid (resultado_valid),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .overrun         (overrun),
        .cnt_overrun     (cnt_overrun),
        .cnt_muestras    (cnt_muestras)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] m, input logic l,
                                 input logic [15:0] r, input logic c);
        muestra_valid = v;
        muestra_in    = m;
        eval_listo    = l;
        resultado_in  = r;
        clear_err     = c;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " dato_out"}, 32'(dato_out), 0);
        checkOutput({tag, " start_eval"}, 32'(start_eval), 0);
        checkOutput({tag, " resultado_out"}, 32'(resultado_out), 0);
        checkOutput({tag, " resultado_valid"}, 32'(resultado_valid), 0);
        checkOutput({tag, " busy"}, 32'(busy), 0);
        checkOutput({tag, " timeout_err"}, 32'(timeout_err), 0);
        checkOutput({tag, " overrun"}, 32'(overrun), 0);
        checkOutput({tag, " cnt_overrun"}, 32'(cnt_overrun), 0);
        checkOutput({tag, " cnt_muestras"}, 32'(cnt_muestras), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();
        tick();
        checkAllZero("reset");
        rst_n = 1'b1;
        tick();

        $display("[TB] basic run");
        applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0);           // c0
        tick();                                                     // c1
        checkOutput("basic dato_out c1", 32'(dato_out), 32'h1234);
        checkOutput("basic start c1", 32'(start_eval), 0);
        checkOutput("basic busy c1", 32'(busy), 1);
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();                                                     // c2
        checkOutput("basic start c2", 32'(start_eval), 1);
        tick();                                                     // c3
        checkOutput("basic start c3", 32'(start_eval), 0);
        checkOutput("basic valid c3", 32'(resultado_valid), 0);
        tick();                                                     // c4
        checkOutput("basic valid c4", 32'(resultado_valid), 0);
        applyStimulus(1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0);
        tick();                                                     // c5
        checkOutput("basic valid c5", 32'(resultado_valid), 1);
        checkOutput("basic resultado c5", 32'(resultado_out), 32'hBEEF);
        checkOutput("basic cnt_muestras c5", 32'(cnt_muestras), 1);
        checkOutput("basic busy c5", 32'(busy), 1);
        tick();                                                     // c6
        checkOutput("basic valid c6", 32'(resultado_valid), 0);
        checkOutput("basic busy c6", 32'(busy), 0);

        $display("[TB] stale done");
        applyStimulus(1'b1, 16'h5555, 1'b1, 16'hBEEF, 1'b0);        // c0, listo still high
        tick();                                                     // c1
        applyStimulus(1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0);
        tick();                                                     // c2
        tick();                                                     // c3 first WAIT cycle
        tick();                                                     // c4
        applyStimulus(1'b0, 16'h0, 1'b0, 16'hBEEF, 1'b0);
        for (int c = 4; c <= 8; c++) begin
            checkOutput($sformatf("stale valid c%0d", c), 32'(resultado_valid), 0);
            checkOutput($sformatf("stale busy c%0d", c), 32'(busy), 1);
            tick();
        end                                                         // c9
        checkOutput("stale valid c9", 32'(resultado_valid), 0);
        applyStimulus(1'b0, 16'h0, 1'b1, 16'hCAFE, 1'b0);
        tick();                                                     // c10
        checkOutput("stale valid c10", 32'(resultado_valid), 1);
        checkOutput("stale resultado c10", 32'(resultado_out), 32'hCAFE);
        checkOutput("stale cnt_muestras c10", 32'(cnt_muestras), 2);
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();                                                     // c11
        checkOutput("stale busy c11", 32'(busy), 0);

        $display("[TB] timeout");
        applyStimulus(1'b1, 16'h0F0F, 1'b0, 16'h0, 1'b0);           // c0
        tick();                                                     // c1
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        for (int c = 1; c <= 17; c++) begin
            checkOutput($sformatf("timeout valid c%0d", c), 32'(resultado_valid), 0);
            tick();
        end                                                         // c18 last WAIT cycle
        checkOutput("timeout err c18", 32'(timeout_err), 0);
        checkOutput("timeout busy c18", 32'(busy), 1);
        tick();                                                     // c19
        checkOutput("timeout err c19", 32'(timeout_err), 1);
        checkOutput("timeout busy c19", 32'(busy), 0);
        checkOutput("timeout valid c19", 32'(resultado_valid), 0);
        checkOutput("timeout cnt_muestras", 32'(cnt_muestras), 2);
        applyStimulus(1'b1, 16'h7777, 1'b0, 16'h0, 1'b0);
        tick();                                                     // c20 (new c1)
        checkOutput("after timeout dato_out", 32'(dato_out), 32'h7777);
        checkOutput("after timeout busy", 32'(busy), 1);
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();                                                     // c2
        tick();                                                     // c3
        tick();                                                     // c4
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h1111, 1'b0);
        tick();                                                     // c5
        checkOutput("after timeout valid", 32'(resultado_valid), 1);
        checkOutput("after timeout resultado", 32'(resultado_out), 32'h1111);
        checkOutput("after timeout cnt_muestras", 32'(cnt_muestras), 3);
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();                                                     // idle

        $display("[TB] overrun");
        applyStimulus(1'b1, 16'hAAAA, 1'b0, 16'h0, 1'b0);           // c0
        tick();                                                     // c1
        applyStimulus(1'b1, 16'hDEAD, 1'b0, 16'h0, 1'b0);
        tick();                                                     // c2
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();                                                     // c3
        applyStimulus(1'b1, 16'hBEAD, 1'b0, 16'h0, 1'b0);
        tick();                                                     // c4
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();                                                     // c5
        applyStimulus(1'b1, 16'hF00D, 1'b0, 16'h0, 1'b0);
        tick();                                                     // c6
        checkOutput("overrun cnt", 32'(cnt_overrun), 3);
        checkOutput("overrun flag", 32'(overrun), 1);
        checkOutput("overrun dato_out", 32'(dato_out), 32'hAAAA);
        checkOutput("overrun timeout_err kept", 32'(timeout_err), 1);
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h2222, 1'b0);
        tick();                                                     // c7
        checkOutput("overrun valid", 32'(resultado_valid), 1);
        checkOutput("overrun cnt_muestras", 32'(cnt_muestras), 4);
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();                                                     // idle

        $display("[TB] clear_err");
        applyStimulus(1'b1, 16'h3333, 1'b0, 16'h0, 1'b0);           // c0
        tick();                                                     // c1
        applyStimulus(1'b1, 16'h4444, 1'b0, 16'h0, 1'b1);
        tick();                                                     // c2
        checkOutput("clear+drop overrun", 32'(overrun), 1);
        checkOutput("clear+drop cnt_overrun", 32'(cnt_overrun), 4);
        checkOutput("clear+drop timeout_err", 32'(timeout_err), 0);
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        tick();                                                     // c3 WAIT timer 0
        checkOutput("clear overrun", 32'(overrun), 0);
        checkOutput("clear timeout_err", 32'(timeout_err), 0);
        checkOutput("clear cnt_overrun", 32'(cnt_overrun), 4);
        checkOutput("clear cnt_muestras", 32'(cnt_muestras), 4);
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();                                                     // c4 WAIT timer 1

        $display("[TB] reset in WAIT");
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h9999, 1'b0);
        tick();
        checkAllZero("midrun reset");
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();
        checkOutput("post reset busy", 32'(busy), 0);
        checkOutput("post reset valid", 32'(resultado_valid), 0);
        applyStimulus(1'b1, 16'h6666, 1'b0, 16'h0, 1'b0);
        tick();
        checkOutput("post reset dato_out", 32'(dato_out), 32'h6666);
        checkOutput("post reset busy run", 32'(busy), 1);

        $display("[TB] overrun saturation");
        for (int i = 0; i < 340; i++) tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();
        checkOutput("sat cnt_overrun", 32'(cnt_overrun), 255);
        checkOutput("sat overrun", 32'(overrun), 1);
        checkOutput("sat timeout_err", 32'(timeout_err), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
